frs_message_queue: RTL and testbench
====================================

// Module: frs_message_queue
// PURPOSE
//  Receive-side FRS (Function Readiness Status) message queue for a Root Port / RCEC.
//  - Buffers incoming FRS messages (Function ID + Reason) in a FIFO.
//  - Implements the FRS Queueing Status, Control and Message Queue registers.
//  - Raises an MSI/MSI-X request; depth feeds the FRS Queueing Capability register.
// PARAMETERS
//  DEPTH      8  queue entries, 1..64; any value, not restricted to powers of 2
//  PTR_W      $clog2(DEPTH) (min 1)  pointer width, derived, do not override
// PORTS
//  clk              in   1   core clock; single clock domain
//  rst_n            in   1   asynchronous active-low reset
//  msg_valid        in   1   one FRS message presented this cycle (posted, no backpressure)
//  msg_func_id      in   16  Function ID of message (Bus/Dev/Fn)
//  msg_reason       in   4   FRS Reason code
//  reg_wr_en        in   1   config write strobe
//  reg_rd_en        in   1   config read strobe
//  reg_addr         in   1   0: Status[15:0]/Control[31:16]; 1: Message Queue
//  reg_wdata        in   32  write data
//  reg_rdata        out  32  read data, valid when reg_rdata_valid
//  reg_rdata_valid  out  1   one-cycle pulse, 1 clk after reg_rd_en
//  irq_req          out  1   one-cycle interrupt request pulse
//  queue_max_depth  out  12  constant DEPTH-1, to FRS Queue Max Depth field
//  queue_count      out  7   current number of valid entries
// BEHAVIOUR
//  Reset: FIFO empty, rd/wr ptr=0, count=0, msg_received=0, msg_overflow=0, int_en=0.
//         All outputs read 0 except queue_max_depth.
//  Register map:
//   addr0 read : {15'b0, int_en, 14'b0, msg_overflow, msg_received}
//   addr0 write: bit0/bit1 RW1C on msg_received/msg_overflow; bit16 RW int_en
//   addr1 read : {12'b0, head_reason, head_func_id}; all zeros when queue empty
//   addr1 write: any value pops oldest entry; no effect when empty
//  Enqueue:
//   - msg_valid & (count<DEPTH): write entry at wr_ptr, wr_ptr advances, set msg_received.
//   - msg_valid & full: message dropped, set msg_overflow; queue contents unchanged.
//   - Same cycle pop and push while full: pop applied first, push accepted.
//     count unchanged, no overflow.
//   - Push and pop same cycle, not full/empty: count unchanged, both ptrs advance.
//  Pointers: wrap DEPTH-1 -> 0 explicitly; count is the single full/empty source.
//  Set priority: a hardware set in the same cycle as an RW1C clear leaves the bit set.
//  Read: reg_rdata registered; value sampled at reg_rd_en cycle (pre-pop if write same cycle).
//   Read and write in the same cycle are both honoured.
//  Interrupt: irq_req=1 for one cycle on rising edge of (msg_received & int_en):
//   - fires on first message with int_en=1, or when int_en written 1 while received=1.
//   - Further messages while received already set do not re-fire until W1C clears it.
//  Reset mid-operation: async clear of all state; pending irq and rdata_valid drop at once.
//  Overflow does not clear itself; software must W1C.
// TESTING
//  1 Reset, read addr0/addr1 -> 0x0/0x0; queue_max_depth=DEPTH-1=7.
//  2 int_en=1, push (0x0108,0x2) -> irq_req 1 pulse.
//    Read addr1 -> 0x0002_0108; write addr1 -> count 0.
//  3 Push 9 messages (DEPTH=8) -> count=8, msg_overflow=1.
//    8 pops return messages 1..8 in order; 9th read=0.
//  4 Full queue, push + addr1 write same cycle -> count stays 8, no overflow.
//    New head is message 2.
//  5 W1C addr0=0x1 same cycle as msg_valid -> msg_received stays 1, no 2nd irq_req.
//    Clear then push -> irq_req.
//  6 Assert rst_n low with count=5 and int_en=1 -> all state zero, irq_req=0 immediately.

Source files
------------

// File: rtl/frs_message_queue.sv
// Receive-side FRS message queue: buffers Function ID + Reason pairs and exposes
// the FRS Queueing Status/Control and Message Queue registers plus an interrupt pulse.
module frs_message_queue #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        msg_valid,
   input  logic [15:0] msg_func_id,
   input  logic [3:0]  msg_reason,
   input  logic        reg_wr_en,
   input  logic        reg_rd_en,
   input  logic        reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic        reg_rdata_valid,
   output logic        irq_req,
   output logic [11:0] queue_max_depth,
   output logic [6:0]  queue_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [6:0]       DEPTH_C = 7'(DEPTH);
   localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

   logic [19:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [6:0]       count;
   logic             msg_received, msg_overflow, int_en;
   logic             irq_q, rdata_valid_q;
   logic [31:0]      rdata_q;

   logic             empty, full, pop, push, drop, ctrl_wr;
   logic             received_next, overflow_next, int_en_next;
   logic [6:0]       count_next;
   logic [31:0]      head_word, status_word, rd_mux;
   logic             unused_wdata;

   assign unused_wdata = ^{reg_wdata[31:17], reg_wdata[15:2]};

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      empty   = (count == 7'd0);
      full    = (count == DEPTH_C);
      pop     = reg_wr_en & reg_addr & ~empty;
      // a pop in the same cycle frees a slot, so a full queue still accepts the push
      push    = msg_valid & (~full | pop);
      drop    = msg_valid & ~push;
      ctrl_wr = reg_wr_en & ~reg_addr;

      // hardware set wins over a simultaneous W1C
      received_next = (msg_received & ~(ctrl_wr & reg_wdata[0])) | push;
      overflow_next = (msg_overflow & ~(ctrl_wr & reg_wdata[1])) | drop;
      int_en_next   = ctrl_wr ? reg_wdata[16] : int_en;

      count_next = count;
      if (push & ~pop)
         count_next = count + 7'd1;
      else if (pop & ~push)
         count_next = count - 7'd1;

      head_word   = empty ? 32'd0 : {12'd0, mem[rd_ptr]};
      status_word = {15'd0, int_en, 14'd0, msg_overflow, msg_received};
      rd_mux      = reg_addr ? head_word : status_word;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {msg_reason, msg_func_id};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         msg_received    <= 1'b0;
         msg_overflow    <= 1'b0;
         int_en          <= 1'b0;
         irq_q           <= 1'b0;
         rdata_valid_q   <= 1'b0;
         rdata_q         <= '0;
      end else begin
         if (push)
            wr_ptr <= bump(wr_ptr);
         if (pop)
            rd_ptr <= bump(rd_ptr);
         count         <= count_next;
         msg_received  <= received_next;
         msg_overflow  <= overflow_next;
         int_en        <= int_en_next;
         irq_q         <= received_next & int_en_next & ~(msg_received & int_en);
         rdata_valid_q <= reg_rd_en;
         if (reg_rd_en)
            rdata_q <= rd_mux;
         else
            rdata_q <= '0;
      end
   end

   assign reg_rdata       = rdata_q;
   assign reg_rdata_valid = rdata_valid_q;
   assign irq_req         = irq_q;
   assign queue_count     = count;
   assign queue_max_depth = 12'(DEPTH - 1);

endmodule

// File: tb/tb_frs_message_queue.sv
// Scoreboard bench for frs_message_queue: a queue-based reference model predicts
// per-cycle irq/count/read data; a negedge monitor compares against the DUT.
module tb_frs_message_queue;

   localparam int DEPTH = 8;

   logic        clk, rst_n;
   logic        msg_valid;
   logic [15:0] msg_func_id;
   logic [3:0]  msg_reason;
   logic        reg_wr_en, reg_rd_en, reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_rdata_valid, irq_req;
   logic [11:0] queue_max_depth;
   logic [6:0]  queue_count;

   frs_message_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .msg_valid(msg_valid), .msg_func_id(msg_func_id), .msg_reason(msg_reason),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rdata_valid(reg_rdata_valid),
      .irq_req(irq_req), .queue_max_depth(queue_max_depth), .queue_count(queue_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          has_rd;
      logic [31:0] rd;
      bit          irq;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // reference model state
   logic [19:0] m_q[$];
   bit m_rcv, m_ovf, m_ie, m_lvl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rcv = 0; m_ovf = 0; m_ie = 0; m_lvl = 0;
   endtask

   task automatic cycle(input bit mv, input logic [15:0] fid, input logic [3:0] rsn,
                        input bit we, input bit re, input bit ad, input logic [31:0] wd);
      exp_t e;
      bit set_rcv, set_ovf, lvl;
      msg_valid = mv; msg_func_id = fid; msg_reason = rsn;
      reg_wr_en = we; reg_rd_en = re; reg_addr = ad; reg_wdata = wd;
      e.has_rd = re;
      e.rd = 32'd0;
      if (re) begin
         if (!ad) e.rd = {15'd0, m_ie, 14'd0, m_ovf, m_rcv};
         else if (m_q.size() > 0) e.rd = {12'd0, m_q[0]};
      end
      if (we && ad && m_q.size() > 0) void'(m_q.pop_front());
      set_rcv = 0; set_ovf = 0;
      if (mv) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back({rsn, fid});
            set_rcv = 1;
         end else set_ovf = 1;
      end
      if (we && !ad) begin
         if (wd[0]) m_rcv = 0;
         if (wd[1]) m_ovf = 0;
         m_ie = wd[16];
      end
      m_rcv = m_rcv | set_rcv;
      m_ovf = m_ovf | set_ovf;
      lvl   = m_rcv & m_ie;
      e.irq = lvl & ~m_lvl;
      m_lvl = lvl;
      e.cnt = m_q.size();
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      msg_valid = 0; reg_wr_en = 0; reg_rd_en = 0; reg_addr = 0; reg_wdata = 0;
   endtask

   task automatic push_msg(input logic [15:0] fid, input logic [3:0] rsn);
      cycle(1, fid, rsn, 0, 0, 0, 0);
   endtask
   task automatic rd(input bit ad);
      cycle(0, 0, 0, 0, 1, ad, 0);
   endtask
   task automatic wr(input bit ad, input logic [31:0] wd);
      cycle(0, 0, 0, 1, 0, ad, wd);
   endtask
   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("irq_req", {31'd0, irq_req}, {31'd0, e.irq});
         chk("queue_count", {25'd0, queue_count}, e.cnt);
         chk("rdata_valid", {31'd0, reg_rdata_valid}, {31'd0, e.has_rd});
         if (e.has_rd) chk("reg_rdata", reg_rdata, e.rd);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      msg_valid = 0; msg_func_id = 0; msg_reason = 0;
      reg_wr_en = 0; reg_rd_en = 0; reg_addr = 0; reg_wdata = 0;
      model_reset();
      #1;
      chk("reset_count", {25'd0, queue_count}, 0);
      chk("reset_irq", {31'd0, irq_req}, 0);
      chk("reset_rvalid", {31'd0, reg_rdata_valid}, 0);
      chk("max_depth", {20'd0, queue_max_depth}, DEPTH - 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // 1: reset register values
      rd(0); rd(1);

      // 2: interrupt on first message, head read then pop
      wr(0, 32'h0001_0000);
      push_msg(16'h0108, 4'h2);
      rd(1);
      wr(1, 0);
      idle();

      // 3: overflow and FIFO order
      for (int i = 1; i <= 9; i++) push_msg(16'h0100 + 16'(i), 4'(i));
      rd(0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 1, 0);
      rd(1);

      // 4: push + pop while full
      wr(0, 32'h0001_0002);
      for (int i = 1; i <= 8; i++) push_msg(16'h0200 + 16'(i), 4'(i));
      cycle(1, 16'h0209, 4'h9, 1, 0, 1, 0);
      rd(0); rd(1);

      // 5: W1C racing a set, then clear and push
      for (int i = 0; i < 8; i++) wr(1, 0);
      cycle(1, 16'h0301, 4'h3, 1, 0, 0, 32'h0001_0001);
      idle();
      wr(0, 32'h0001_0001);
      push_msg(16'h0302, 4'h4);
      rd(0);

      // 6: async reset mid-operation with irq and rdata_valid pending
      for (int i = 0; i < 8; i++) wr(1, 0);
      for (int i = 0; i < 4; i++) push_msg(16'h0400 + 16'(i), 4'(i));
      wr(0, 32'h0001_0001);
      cycle(1, 16'h0404, 4'h4, 0, 1, 0, 0);
      chk("pre_reset_irq", {31'd0, irq_req}, 1);
      chk("pre_reset_count", {25'd0, queue_count}, 5);
      exp_q.delete();
      rst_n = 0;
      #1;
      chk("mid_reset_irq", {31'd0, irq_req}, 0);
      chk("mid_reset_rvalid", {31'd0, reg_rdata_valid}, 0);
      chk("mid_reset_count", {25'd0, queue_count}, 0);
      chk("mid_reset_rdata", reg_rdata, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      rd(0); rd(1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit mv, we, re, ad;
         logic [31:0] wd;
         mv = ($urandom_range(0, 99) < 50);
         re = ($urandom_range(0, 99) < 30);
         we = ($urandom_range(0, 99) < 35);
         ad = ($urandom_range(0, 99) < 75);
         wd = $urandom;
         if ($urandom_range(0, 3) != 0) wd[16] = 1'b1;
         cycle(mv, 16'($urandom), 4'($urandom), we, re, ad, wd);
      end

      idle(); idle();
      @(posedge clk); @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
